// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Purpose: loader FSM state type, header width and the word-address helper.
// Ports: none (package).
package imem_loader_pkg;

  // Width of the little-endian program-length header, in bits.
  localparam int HDR_WIDTH = 16;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    RUN,
    ERR
  } loader_state_t;

  // Word index to word-aligned byte address.
  function automatic logic [31:0] word_addr(input logic [HDR_WIDTH-1:0] idx);
    return {{(32-HDR_WIDTH-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory
// Purpose: receives a 2-byte word count followed by little-endian 32-bit words,
//          writes each word to instruction memory, then releases the processor.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rx_valid, rx_data  - upstream byte stream (byte taken when rx_ready is high)
//   rx_ready           - loader accepts a byte this cycle
//   im_we/addr/wdata   - instruction-memory write port (one-cycle strobe)
//   cpu_rst            - processor reset, high until the program is loaded
//   done, err          - loaded and released / header rejected
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  loader_state_t        state, state_nx;
  logic [7:0]           count_lo;
  logic [HDR_WIDTH-1:0] count;
  logic [HDR_WIDTH-1:0] word_idx;
  logic [1:0]           byte_cnt;
  logic [23:0]          asm_word;   // the first three bytes of the word in flight

  logic                 accept;
  logic [HDR_WIDTH-1:0] hdr_count;
  logic                 word_done;
  logic                 last_byte;
  logic [31:0]          full_word;

  assign accept    = rx_valid & rx_ready;
  assign hdr_count = {rx_data, count_lo};
  assign word_done = (byte_cnt == 2'd3);
  assign last_byte = word_done && (word_idx == count - HDR_WIDTH'(1));
  assign full_word = {rx_data, asm_word};

  always_ff @(posedge clk) begin
    if (rst) state <= HDR_LO;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR_LO: if (accept) state_nx = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if (hdr_count == '0)
            state_nx = RUN;
          else if ({{(32-HDR_WIDTH){1'b0}}, hdr_count} > MAX_W)
            state_nx = ERR;
          else
            state_nx = LOAD;
        end
      end
      LOAD:    if (accept && last_byte) state_nx = RUN;
      default: state_nx = state;  // RUN and ERR are left only through rst
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_lo <= '0;
      count    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      rx_ready <= 1'b1;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR_LO: count_lo <= rx_data;
          HDR_HI: count    <= hdr_count;
          LOAD: begin
            // Shift right so the first byte of a word ends up in [7:0].
            asm_word <= full_word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (word_done) begin
              im_we    <= 1'b1;
              im_addr  <= word_addr(word_idx);
              im_wdata <= full_word;
              word_idx <= word_idx + HDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
      rx_ready <= (state_nx == HDR_LO) || (state_nx == HDR_HI) || (state_nx == LOAD);
      // Release lags RUN entry by a cycle so the final write lands before the
      // processor leaves reset.
      cpu_rst  <= (state != RUN);
      done     <= (state == RUN);
      err      <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Purpose: drives header/payload byte streams and checks writes, handshake and status.
// Ports: none (top-level bench).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic        prev_cpu_rst = 1'b1;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          fall_cyc[$];

  logic [7:0] basic [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
                             8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

  // Log every write and every cpu_rst falling edge with its cycle number.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      wr_cyc.push_back(cyc);
    end
    if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) fall_cyc.push_back(cyc);
    prev_cpu_rst <= cpu_rst;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int get_wcyc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -100;
  endfunction

  function automatic int get_fcyc(input int i);
    return (i < fall_cyc.size()) ? fall_cyc[i] : -200;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_im_we"},    32'(im_we),    32'd0);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic run_basic(input int gap, input string tag);
    int wb;
    int fb;
    wb = wr_addr.size();
    fb = fall_cyc.size();
    for (int i = 0; i < 10; i++) send(basic[i], gap);
    idle(4);
    check({tag, "_nwr"},   32'(wr_addr.size() - wb), 32'd2);
    check({tag, "_addr0"}, get_addr(wb),     32'h0000_0000);
    check({tag, "_data0"}, get_data(wb),     32'h0010_0513);
    check({tag, "_addr1"}, get_addr(wb + 1), 32'h0000_0004);
    check({tag, "_data1"}, get_data(wb + 1), 32'h0020_0593);
    check({tag, "_wr_spacing"}, 32'(get_wcyc(wb + 1) - get_wcyc(wb)), 32'(4 * (gap + 1)));
    check({tag, "_nfall"}, 32'(fall_cyc.size() - fb), 32'd1);
    check({tag, "_fall_after_wr"}, 32'(get_fcyc(fb) - get_wcyc(wb + 1)), 32'd1);
    check({tag, "_done"},     32'(done),     32'd1);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    int wb;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Back-to-back two-word program.
    run_basic(0, "basic");

    // Bytes offered after release are ignored.
    wb = wr_addr.size();
    for (int i = 0; i < 10; i++) send(8'(8'h40 + i), 0);
    idle(3);
    check("post_nwr",      32'(wr_addr.size() - wb), 32'd0);
    check("post_done",     32'(done),     32'd1);
    check("post_rx_ready", 32'(rx_ready), 32'd0);
    check("post_cpu_rst",  32'(cpu_rst),  32'd0);

    // Same program with three idle cycles before every byte.
    do_reset();
    check_reset_state("reset2");
    run_basic(3, "gapped");

    // Empty program: release one cycle after RUN is entered.
    do_reset();
    wb = wr_addr.size();
    send(8'h00, 0);
    send(8'h00, 0);
    idle(1);
    check("empty_run_cpu_rst",  32'(cpu_rst),  32'd1);
    check("empty_run_rx_ready", 32'(rx_ready), 32'd0);
    idle(1);
    check("empty_cpu_rst",  32'(cpu_rst),  32'd0);
    check("empty_done",     32'(done),     32'd1);
    check("empty_rx_ready", 32'(rx_ready), 32'd0);
    idle(2);
    check("empty_nwr", 32'(wr_addr.size() - wb), 32'd0);

    // Oversize header N=257.
    do_reset();
    wb = wr_addr.size();
    send(8'h01, 0);
    send(8'h01, 0);
    idle(1);
    check("over_err",      32'(err),      32'd1);
    check("over_cpu_rst",  32'(cpu_rst),  32'd1);
    check("over_rx_ready", 32'(rx_ready), 32'd0);
    check("over_done",     32'(done),     32'd0);
    for (int i = 0; i < 8; i++) send(8'(8'h10 * i + 1), 0);
    idle(3);
    check("over_nwr",       32'(wr_addr.size() - wb), 32'd0);
    check("over_err_hold",  32'(err),     32'd1);
    check("over_cpu_hold",  32'(cpu_rst), 32'd1);

    // Reset mid-word, with a byte offered on the reset edge.
    do_reset();
    wb = wr_addr.size();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    check_reset_state("midrst");
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
    idle(4);
    check("midrst_nwr",  32'(wr_addr.size() - wb), 32'd1);
    check("midrst_addr", get_addr(wb), 32'h0000_0000);
    check("midrst_data", get_data(wb), 32'hDDCC_BBAA);
    check("midrst_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
